// File: rtl/dcache_fill_ctrl_if.sv
// LSU miss, shared memory bus and cache fill-port signals of the data cache fill engine.
// master is the fill engine's view, slave is the LSU/memory/cache environment's view.
interface dcache_fill_ctrl_if #(
  parameter int MEM_TAG_W = 4
);
  logic                 miss_valid;
  logic [63:0]          miss_addr;
  logic                 miss_ready;
  logic                 flush;
  logic                 mem_busy;
  logic [1:0]           proc2mem_command;
  logic [63:0]          proc2mem_addr;
  logic [MEM_TAG_W-1:0] mem2proc_response;
  logic [63:0]          mem2proc_data;
  logic [MEM_TAG_W-1:0] mem2proc_tag;
  logic                 wr1_en;
  logic [4:0]           wr1_idx;
  logic [7:0]           wr1_tag;
  logic [63:0]          wr1_data;
  logic                 fill_done;
  logic [63:0]          fill_addr;

  modport master (
    input  miss_valid, miss_addr, flush, mem_busy,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output miss_ready, proc2mem_command, proc2mem_addr,
    output wr1_en, wr1_idx, wr1_tag, wr1_data, fill_done, fill_addr
  );

  modport slave (
    output miss_valid, miss_addr, flush, mem_busy,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  miss_ready, proc2mem_command, proc2mem_addr,
    input  wr1_en, wr1_idx, wr1_tag, wr1_data, fill_done, fill_addr
  );
endinterface

// File: rtl/dcache_fill_ctrl.sv
// D-cache miss/fill engine with an MSHR file; DCACHE_FILL_MERGE_EN merges duplicate misses into one entry.
// Issue is combinational, fills land one cycle after the tagged response; miss_ready drops when all MSHRs are busy.
module dcache_fill_ctrl #(
  parameter int MSHR_DEPTH = 4,
  parameter int MEM_TAG_W  = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  dcache_fill_ctrl_if.master io_bus
);

  localparam int IW = (MSHR_DEPTH > 1) ? $clog2(MSHR_DEPTH) : 1;
  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_ISSUE = 2'd1,
    WAIT_DATA  = 2'd2
  } mshr_state_e;

  mshr_state_e          r_state    [MSHR_DEPTH];
  logic [60:0]          r_addr     [MSHR_DEPTH];
  logic [MEM_TAG_W-1:0] r_mtag     [MSHR_DEPTH];
  logic [MSHR_DEPTH-1:0] r_notify;

  mshr_state_e          w_state_nxt [MSHR_DEPTH];
  logic [60:0]          w_addr_nxt  [MSHR_DEPTH];
  logic [MEM_TAG_W-1:0] w_mtag_nxt  [MSHR_DEPTH];
  logic [MSHR_DEPTH-1:0] w_notify_nxt;

  logic          r_wr1_en;
  logic [4:0]    r_wr1_idx;
  logic [7:0]    r_wr1_tag;
  logic [63:0]   r_wr1_data;
  logic          r_fill_done;
  logic [63:0]   r_fill_addr;

  logic          w_alloc_vld, w_iss_vld, w_rsp_vld, w_mrg_vld;
  logic [IW-1:0] w_alloc_idx, w_iss_idx, w_rsp_idx, w_mrg_idx;
  logic          w_miss_rdy, w_accept, w_do_alloc, w_do_merge;
  logic          w_cmd_vld, w_issued, w_fill_ntf;
  logic [2:0]    w_unused_low_bits;

  assign w_unused_low_bits = io_bus.miss_addr[2:0];

  // Descending scan so the lowest-numbered matching entry wins each search.
  always_comb begin
    w_alloc_vld = 1'b0;
    w_alloc_idx = '0;
    w_iss_vld   = 1'b0;
    w_iss_idx   = '0;
    w_rsp_vld   = 1'b0;
    w_rsp_idx   = '0;
    w_mrg_vld   = 1'b0;
    w_mrg_idx   = '0;
    for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
      if (r_state[i] == IDLE) begin
        w_alloc_vld = 1'b1;
        w_alloc_idx = IW'(i);
      end
      if (r_state[i] == WAIT_ISSUE) begin
        w_iss_vld = 1'b1;
        w_iss_idx = IW'(i);
      end
      if (r_state[i] == WAIT_DATA && io_bus.mem2proc_tag != '0 &&
          r_mtag[i] == io_bus.mem2proc_tag) begin
        w_rsp_vld = 1'b1;
        w_rsp_idx = IW'(i);
      end
`ifdef DCACHE_FILL_MERGE_EN
      if (r_state[i] != IDLE && r_addr[i] == io_bus.miss_addr[63:3]) begin
        w_mrg_vld = 1'b1;
        w_mrg_idx = IW'(i);
      end
`endif
    end
  end

  assign w_miss_rdy = (w_alloc_vld | w_mrg_vld) & ~io_bus.flush;
  assign w_accept   = io_bus.miss_valid & w_miss_rdy;
  assign w_do_merge = w_accept & w_mrg_vld;
  assign w_do_alloc = w_accept & ~w_mrg_vld;
  assign w_cmd_vld  = w_iss_vld & ~io_bus.mem_busy & ~io_bus.flush;
  assign w_issued   = w_cmd_vld & (io_bus.mem2proc_response != '0);

  // A merge into an entry completing this same cycle must still notify the LSU.
  assign w_fill_ntf = (r_notify[w_rsp_idx] & ~io_bus.flush) |
                      (w_do_merge & (w_mrg_idx == w_rsp_idx));

  assign io_bus.miss_ready       = w_miss_rdy;
  assign io_bus.proc2mem_command = w_cmd_vld ? CMD_LOAD : CMD_NONE;
  assign io_bus.proc2mem_addr    = w_cmd_vld ? {r_addr[w_iss_idx], 3'b000} : 64'd0;

  always_comb begin
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_addr_nxt[i]  = r_addr[i];
      w_mtag_nxt[i]  = r_mtag[i];
    end
    w_notify_nxt = r_notify;

    if (io_bus.flush) begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        if (r_state[i] == WAIT_ISSUE) begin
          w_state_nxt[i] = IDLE;
        end
        w_notify_nxt[i] = 1'b0;
      end
    end

    if (w_issued) begin
      w_state_nxt[w_iss_idx] = WAIT_DATA;
      w_mtag_nxt[w_iss_idx]  = io_bus.mem2proc_response;
    end

    if (w_rsp_vld) begin
      w_state_nxt[w_rsp_idx] = IDLE;
    end

    if (w_do_alloc) begin
      w_state_nxt[w_alloc_idx]  = WAIT_ISSUE;
      w_addr_nxt[w_alloc_idx]   = io_bus.miss_addr[63:3];
      w_notify_nxt[w_alloc_idx] = 1'b1;
    end

    if (w_do_merge) begin
      w_notify_nxt[w_mrg_idx] = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        r_state[i] <= IDLE;
        r_addr[i]  <= '0;
        r_mtag[i]  <= '0;
      end
      r_notify <= '0;
    end else begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_addr[i]  <= w_addr_nxt[i];
        r_mtag[i]  <= w_mtag_nxt[i];
      end
      r_notify <= w_notify_nxt;
    end
  end

  // Fill port and completion are single-cycle pulses; everything returns to zero when idle.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wr1_en    <= 1'b0;
      r_wr1_idx   <= '0;
      r_wr1_tag   <= '0;
      r_wr1_data  <= '0;
      r_fill_done <= 1'b0;
      r_fill_addr <= '0;
    end else if (w_rsp_vld) begin
      r_wr1_en    <= 1'b1;
      r_wr1_idx   <= r_addr[w_rsp_idx][4:0];
      r_wr1_tag   <= r_addr[w_rsp_idx][12:5];
      r_wr1_data  <= io_bus.mem2proc_data;
      r_fill_done <= w_fill_ntf;
      r_fill_addr <= {r_addr[w_rsp_idx], 3'b000};
    end else begin
      r_wr1_en    <= 1'b0;
      r_wr1_idx   <= '0;
      r_wr1_tag   <= '0;
      r_wr1_data  <= '0;
      r_fill_done <= 1'b0;
      r_fill_addr <= '0;
    end
  end

  assign io_bus.wr1_en    = r_wr1_en;
  assign io_bus.wr1_idx   = r_wr1_idx;
  assign io_bus.wr1_tag   = r_wr1_tag;
  assign io_bus.wr1_data  = r_wr1_data;
  assign io_bus.fill_done = r_fill_done;
  assign io_bus.fill_addr = r_fill_addr;

endmodule

// File: doc/dcache_fill_ctrl.md
Name: dcache_fill_ctrl

Overview:
- Miss-handling and fill engine for the 32-line direct-mapped, 64-bit-line data cache.
- Accepts load-miss requests from the LSU and holds them in a small MSHR file.
- Issues LOAD commands to the shared memory bus and matches tagged memory responses to those entries.
- Drives the cache's fill write port (wr1_*) and returns a completion pulse to the LSU; it is the producer side of the cache fill interface.

Parameters:
- MSHR_DEPTH, 4, number of outstanding miss entries (2..8)
- MEM_TAG_W, 4, width of the memory transaction tag; tag value 0 means "no transaction"

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- miss_valid  in  1  LSU presents a miss
- miss_addr  in  64  miss byte address; bits [2:0] ignored
- miss_ready  out  1  miss accepted this cycle when miss_valid is also high
- flush  in  1  pipeline squash
- mem_busy  in  1  bus granted to another requester this cycle
- proc2mem_command  out  2  0=NONE, 1=LOAD
- proc2mem_addr  out  64  request address, 8-byte aligned
- mem2proc_response  in  MEM_TAG_W  nonzero means the request was accepted and assigned this tag
- mem2proc_data  in  64  response data
- mem2proc_tag  in  MEM_TAG_W  nonzero means data for this tag is valid this cycle
- wr1_en  out  1  cache fill write enable
- wr1_idx  out  5  cache index, addr[7:3]
- wr1_tag  out  8  cache tag, addr[15:8]
- wr1_data  out  64  fill data
- fill_done  out  1  completion pulse to LSU
- fill_addr  out  64  aligned address of the completed fill

Behaviour:
- MSHR entry fields: valid, state (IDLE / WAIT_ISSUE / WAIT_DATA), addr[63:3], mem_tag, notify.
- Reset: all entries IDLE with notify=0; proc2mem_command=0; proc2mem_addr=0; wr1_en=0; wr1_idx=0; wr1_tag=0; wr1_data=0; fill_done=0; fill_addr=0.
- Reset mid-operation drops every outstanding miss. Responses arriving after reset are ignored because no entry matches.
- Allocation:
  - miss_ready is combinational: high when any entry is IDLE and flush=0.
  - On miss_valid & miss_ready, the lowest-numbered IDLE entry moves to WAIT_ISSUE with notify=1 at the next edge.
- Issue:
  - The lowest-numbered WAIT_ISSUE entry drives proc2mem_command=1 and proc2mem_addr={addr,3'b0} combinationally, unless mem_busy=1 or flush=1, in which case the command is NONE.
  - If mem2proc_response!=0 in the same cycle, the entry moves to WAIT_DATA and latches mem_tag=mem2proc_response.
  - If mem2proc_response==0, the entry stays in WAIT_ISSUE and retries next cycle.
  - Only one issue per cycle.
- Response:
  - If mem2proc_tag!=0 matches a WAIT_DATA entry's mem_tag, that entry returns to IDLE at the edge.
  - Registered outputs at the next cycle (latency 1):
    - wr1_en=1
    - wr1_idx=addr[7:3]
    - wr1_tag=addr[15:8]
    - wr1_data=mem2proc_data
    - fill_done=entry.notify
    - fill_addr=aligned address
  - All of these deassert the following cycle unless another response arrives.
  - A tag matching no entry (e.g. an icache transaction) is ignored.
  - At most one entry matches, because memory tags are unique while outstanding.
- Flush:
  - WAIT_ISSUE entries go to IDLE.
  - WAIT_DATA entries stay but clear notify: the cache is still filled and fill_done stays 0.
  - No allocation and no issue in a flush cycle.
  - A response in a flush cycle still completes, with fill_done=0.
- Simultaneous events:
  - An entry freed by a response at an edge is allocatable from the following cycle, not the same one.
  - Allocation, issue and response may all occur in one cycle on different entries.
  - An entry issued this cycle cannot receive data this cycle.
- Full: with all MSHR_DEPTH entries non-IDLE, miss_ready=0 and the LSU holds miss_valid and miss_addr stable.

Optional Feature:
- DCACHE_FILL_MERGE_EN defined:
  - A miss whose addr[63:3] equals any non-IDLE entry is accepted (miss_ready=1 even when full) without allocating.
  - If the matching entry's notify=0, it is set to 1.
  - No second LOAD is issued.
- Undefined: duplicates allocate their own entry and issue separately; each produces its own fill and fill_done.

Test Plan:
- Single miss 0x1238, response tag 3 the same cycle, data 0xDEADBEEF at tag 3 five cycles later -> next cycle wr1_en=1, wr1_idx=7, wr1_tag=0x12, wr1_data=0xDEADBEEF, fill_done=1, fill_addr=0x1238.
- Four misses back-to-back with mem2proc_response=0 for 3 cycles -> miss_ready=0 on the fifth miss; issue retries entry 0 each cycle; the bus then accepts tags 1..4 in order over 4 cycles.
- Out-of-order responses tags 4,2,1,3 -> four fills in that order with the matching addresses; no dropped or duplicated wr1_en.
- flush with one entry WAIT_DATA and two WAIT_ISSUE -> no further LOADs issued; the later response writes the cache with fill_done=0; miss_ready=1 the cycle after flush.
- Miss to 0x2000 twice while the first is outstanding -> with the macro, one LOAD and one fill; without it, two LOADs and two fills.
- Assert reset with 3 outstanding entries, release, then drive responses for the old tags -> all outputs 0 throughout, no wr1_en.
